servo_slew_bank: RTL

SERVO_SLEW_BANK -- requirements
Module: servo_slew_bank

---
 rtl/servo_slew_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/servo_slew_bank.sv
// Multi-channel servo PWM generator. Each channel ramps its pulse width toward a
// commanded target by at most SLEW_US per frame, changing only at frame boundaries.
module servo_slew_bank #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int NCH      = 2,
    parameter int POS_W    = 12,
    parameter int FRAME_US = 20000,
    parameter int SLEW_US  = 20,
    parameter int MIN_US   = 500,
    parameter int MAX_US   = 2500,
    parameter int INIT_US  = 1000,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CW-1:0]    cmd_ch,
    input  logic [POS_W-1:0] cmd_pos,
    output logic [NCH-1:0]   pwm_out,
    output logic [NCH-1:0]   settled,
    output logic             frame_tick
);

    localparam int DIV     = CLK_HZ / 1_000_000;
    localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int US_W    = $clog2(FRAME_US + 1);
    localparam int INIT_CL = (INIT_US < MIN_US) ? MIN_US :
                             (INIT_US > MAX_US) ? MAX_US : INIT_US;
    localparam logic [POS_W-1:0]        INIT_V = POS_W'(INIT_CL);
    localparam logic [POS_W-1:0]        SLEW_V = POS_W'(SLEW_US);
    localparam logic signed [POS_W+1:0] SLEW_S = (POS_W + 2)'(SLEW_US);

    logic [PRE_W-1:0]        pre_q;
    logic [US_W-1:0]         us_q;
    logic                    strobe;
    logic                    wrap;
    logic                    accept;
    logic [POS_W-1:0]        pos_cl;
    logic [POS_W-1:0]        cur_q [NCH];
    logic [POS_W-1:0]        cur_d [NCH];
    logic [POS_W-1:0]        tgt_q [NCH];
    logic [POS_W-1:0]        tgt_d [NCH];
    logic signed [POS_W+1:0] diff  [NCH];

    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] p);
        if (32'(p) < MIN_US) return POS_W'(MIN_US);
        if (32'(p) > MAX_US) return POS_W'(MAX_US);
        return p;
    endfunction

    assign strobe    = (pre_q == PRE_W'(DIV - 1));
    assign wrap      = strobe && (us_q == US_W'(FRAME_US - 1));
    assign cmd_ready = !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign pos_cl    = clamp_pos(cmd_pos);

    // Slew uses the old target, so a command coinciding with a boundary only
    // takes effect from the following boundary. Out-of-range channels match no i.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cur_d[i] = cur_q[i];
            tgt_d[i] = tgt_q[i];
            diff[i]  = $signed({2'b00, tgt_q[i]}) - $signed({2'b00, cur_q[i]});
            if (wrap) begin
                if (diff[i] > SLEW_S) begin
                    cur_d[i] = cur_q[i] + SLEW_V;
                end else if (diff[i] < -SLEW_S) begin
                    cur_d[i] = cur_q[i] - SLEW_V;
                end else begin
                    cur_d[i] = tgt_q[i];
                end
            end
            if (accept && (cmd_ch == CW'(i))) begin
                tgt_d[i] = pos_cl;
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            pre_q      <= '0;
            us_q       <= '0;
            pwm_out    <= '0;
            settled    <= '1;
            frame_tick <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= INIT_V;
                tgt_q[i] <= INIT_V;
            end
        end else begin
            pre_q      <= strobe ? '0 : pre_q + PRE_W'(1);
            if (strobe) begin
                us_q <= wrap ? '0 : us_q + US_W'(1);
            end
            frame_tick <= wrap;
            for (int i = 0; i < NCH; i++) begin
                pwm_out[i] <= (32'(us_q) < 32'(cur_q[i]));
                settled[i] <= (cur_d[i] == tgt_d[i]);
                cur_q[i]   <= cur_d[i];
                tgt_q[i]   <= tgt_d[i];
            end
        end
    end

endmodule
